// File: rtl/evr_link_monitor_pkg.sv
// rtl/evr_link_monitor_pkg.sv - shared EVR constants, link state encoding and word classification
package evr_link_monitor_pkg;

  localparam logic [7:0]  COMMA_BYTE     = 8'hBC;
  localparam logic [15:0] IDLE_WORD      = {8'h00, COMMA_BYTE};
  localparam logic [1:0]  IDLE_CHAR_IS_K = 2'b01;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_GTRESET = 2'd3
  } link_state_t;

  // A K flag on the data byte, or any K code other than the comma on the event byte, is treated as corruption.
  function automatic logic word_is_bad(input logic [7:0] event_byte, input logic [1:0] char_is_k,
                                       input logic [1:0] not_in_table, input logic [1:0] disp_err);
    return (|not_in_table) || (|disp_err) || char_is_k[1] ||
           (char_is_k[0] && (event_byte != COMMA_BYTE));
  endfunction

endpackage

// File: rtl/evr_sat_counter.sv
// rtl/evr_sat_counter.sv - saturating up-counter with synchronous clear
module evr_sat_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/evr_link_monitor.sv
// rtl/evr_link_monitor.sv - EVR receive link supervisor: comma lock, error bucket, transceiver reset, word cleaning
module evr_link_monitor
  import evr_link_monitor_pkg::*;
#(
  parameter int    LOCK_COUNT           = 4,
  parameter int    COMMA_TIMEOUT        = 4096,
  parameter int    ERROR_LIMIT          = 8,
  parameter int    RESET_CYCLES         = 16,
  parameter int    STATUS_COUNTER_WIDTH = 10,
  parameter string DEBUG                = "false"
) (
  input  logic                            evrRxClk,
  input  logic                            rst,
  input  logic [15:0]                     gtRxWord,
  input  logic [1:0]                      gtCharIsK,
  input  logic [1:0]                      gtNotInTable,
  input  logic [1:0]                      gtDispErr,
  output logic [15:0]                     evrRxWord,
  output logic [1:0]                      evrCharIsK,
  output logic                            linkUp,
  output logic                            gtRxResetRequest,
  output logic [STATUS_COUNTER_WIDTH-1:0] codeErrorCounter,
  output logic [STATUS_COUNTER_WIDTH-1:0] linkLossCounter
);

  localparam int TW = $clog2(COMMA_TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(ERROR_LIMIT + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  link_state_t   state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [GW-1:0] good_count, good_next;
  logic [LW-1:0] err_level, err_next;
  logic [RW-1:0] reset_count, reset_next;
  logic          word_bad, word_comma, expired;
  logic          pass;
  logic [15:0]   word_out;
  logic [1:0]    k_out;

  assign word_bad   = word_is_bad(gtRxWord[7:0], gtCharIsK, gtNotInTable, gtDispErr);
  assign word_comma = !word_bad && gtCharIsK[0] && (gtRxWord[7:0] == COMMA_BYTE);
  // Expiry fires on the cycle whose increment would reach the timeout.
  assign expired    = !word_comma && (timer == TW'(COMMA_TIMEOUT - 1));

  always_ff @(posedge evrRxClk) begin
    if (rst) begin
      state       <= ST_HUNT;
      timer       <= '0;
      good_count  <= '0;
      err_level   <= '0;
      reset_count <= '0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      good_count  <= good_next;
      err_level   <= err_next;
      reset_count <= reset_next;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_count;
    err_next   = err_level;
    reset_next = '0;
    case (state)
      ST_HUNT: begin
        if (word_comma) begin
          good_next  = GW'(1);
          state_next = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_CHECK;
        end else if (expired) begin
          state_next = ST_GTRESET;
        end
      end
      ST_CHECK: begin
        if (word_comma) begin
          good_next = good_count + GW'(1);
          if (good_next == GW'(LOCK_COUNT)) state_next = ST_LOCKED;
        end else if (word_bad || expired) begin
          state_next = ST_HUNT;
        end
      end
      ST_LOCKED: begin
        if (word_bad) begin
          err_next = err_level + LW'(1);
        end else if (word_comma && (err_level != '0)) begin
          err_next = err_level - LW'(1);
        end
        if ((err_next == LW'(ERROR_LIMIT)) || expired) state_next = ST_GTRESET;
      end
      default: begin
        if (reset_count == RW'(RESET_CYCLES - 1)) state_next = ST_HUNT;
        else reset_next = reset_count + RW'(1);
      end
    endcase
    if ((state_next == ST_HUNT) && (state != ST_HUNT)) begin
      good_next = '0;
      err_next  = '0;
    end
    if (word_comma || (state_next != state)) timer_next = '0;
    else if (timer == TW'(COMMA_TIMEOUT)) timer_next = timer;
    else timer_next = timer + TW'(1);
  end

  always_comb begin
    pass     = (state == ST_LOCKED) && !word_bad;
    word_out = pass ? gtRxWord : IDLE_WORD;
    k_out    = pass ? gtCharIsK : IDLE_CHAR_IS_K;
  end

  always_ff @(posedge evrRxClk) begin
    if (rst) begin
      evrRxWord  <= IDLE_WORD;
      evrCharIsK <= IDLE_CHAR_IS_K;
    end else begin
      evrRxWord  <= word_out;
      evrCharIsK <= k_out;
    end
  end

  assign linkUp           = (state == ST_LOCKED);
  assign gtRxResetRequest = (state == ST_GTRESET);

  evr_sat_counter #(.WIDTH(STATUS_COUNTER_WIDTH)) u_code_error_counter (
    .clk   (evrRxClk),
    .clr   (rst),
    .inc   (word_bad && (state != ST_GTRESET)),
    .count (codeErrorCounter)
  );

  evr_sat_counter #(.WIDTH(STATUS_COUNTER_WIDTH)) u_link_loss_counter (
    .clk   (evrRxClk),
    .clr   (rst),
    .inc   ((state == ST_LOCKED) && (state_next != ST_LOCKED)),
    .count (linkLossCounter)
  );

  generate
    if (DEBUG == "true") begin : g_debug
      (* mark_debug = "true" *) link_state_t debug_state_unused;
      assign debug_state_unused = state;
    end
  endgenerate

endmodule
